// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: STAGES-deep pipelined ripple-carry adder/subtractor with valid/ready flow control
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   io_in_valid/io_in_ready input handshake; io_A, io_B, io_Cin, io_Sub operands and mode
//   io_out_valid/io_out_ready output handshake; io_Sum, io_Cout, io_Ovf result
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    input  logic             io_Cin,
    input  logic             io_Sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_Sum,
    output logic             io_Cout,
    output logic             io_Ovf
);
    localparam int CHUNK = WIDTH / STAGES;
    logic             valid_q [STAGES];
    logic             c_q     [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] s_q     [STAGES];
    logic             ovf_q;
    logic [STAGES:0]  rdy;
    // rdy[k+1] is the downstream readiness seen by stage k; a stage is ready when empty or draining
    always_comb begin
        rdy[STAGES] = io_out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = ~valid_q[k] | rdy[k+1];
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic             v_in, c_in;
        logic [WIDTH-1:0] a_in, b_in, s_in, s_n;
        logic [CHUNK:0]   t;
        if (k == 0) begin : g_first
            assign v_in = io_in_valid;
            assign a_in = io_A;
            assign b_in = io_Sub ? ~io_B : io_B;
            assign c_in = io_Sub ^ io_Cin;
            assign s_in = '0;
        end else begin : g_next
            assign v_in = valid_q[k-1];
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign s_in = s_q[k-1];
        end
        assign t = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_in};
        always_comb begin
            s_n = s_in;
            s_n[k*CHUNK +: CHUNK] = t[CHUNK-1:0];
        end
        // data only loads with a real transfer so outputs stay 0 after reset until a result arrives
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_q[k] <= 1'b0;
                c_q[k]     <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
            end else if (rdy[k]) begin
                valid_q[k] <= v_in;
                if (v_in) begin
                    c_q[k] <= t[CHUNK];
                    a_q[k] <= a_in;
                    b_q[k] <= b_in;
                    s_q[k] <= s_n;
                end
            end
        end
        if (k == STAGES - 1) begin : g_last
            // carry into the MSB is recovered from the MSB sum bit and its operand bits
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    ovf_q <= 1'b0;
                else if (rdy[k] && v_in)
                    ovf_q <= t[CHUNK] ^ (a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ t[CHUNK-1]);
            end
        end
    end
    assign io_in_ready  = rdy[0];
    assign io_out_valid = valid_q[STAGES-1];
    assign io_Sum       = s_q[STAGES-1];
    assign io_Cout      = c_q[STAGES-1];
    assign io_Ovf       = ovf_q;
endmodule
